// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key schedule, forward cipher and
// inverse cipher.
//   Nb         : state width in 32-bit columns
//   word_t     : one 32-bit schedule word, byte 0 in bits 0..7
//   ks_state_t : key schedule FSM encoding, also visible on the debug port
//   sbox()     : forward S-box lookup
//   rcon()     : round constant byte, indexed 1..10 (any other index gives 0)
package aes_pkg;

    localparam int Nb = 4;

    typedef logic [0:31] word_t;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_DONE   = 2'd2
    } ks_state_t;

    // Forward S-box packed so that entry n occupies bits [8n +: 8].
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the forward S-box to each of the four bytes of a word.
// Purely combinational.
//   i_word : input word, byte 0 in bits 0..7
//   o_word : substituted word, same byte order
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [0:31] i_word,
    output logic [0:31] o_word
);

    assign o_word = {sbox(i_word[0:7]),   sbox(i_word[8:15]),
                     sbox(i_word[16:23]), sbox(i_word[24:31])};

endmodule

// File: rtl/key_schedule_unit.sv
// Iterative AES key expansion. Accepts a cipher key over a valid/ready
// handshake, produces one schedule word per clock into a word store, then
// serves any round key through a registered read port.
//
// Handshake: a key transfers on any rising edge where key_valid and
// key_ready are both high and rst is low. key_ready is high whenever the
// unit is not expanding; key_valid is ignored while expanding.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   key_in       : cipher key, bits 0..31 form w[0]
//   key_valid    : key_in is valid
//   key_ready    : unit can accept a key (IDLE or DONE)
//   sched_valid  : full schedule for the last accepted key is stored
//   rk_idx       : round index to read, 0..Nr
//   rk_out       : {w[4r], w[4r+1], w[4r+2], w[4r+3]}, one cycle after rk_idx;
//                  zero when rk_idx > Nr
//   state_dbg    : current FSM state (ks_state_t encoding)
module key_schedule_unit
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:Nk*32-1]  key_in,
    input  logic              key_valid,
    output logic              key_ready,
    output logic              sched_valid,
    input  logic [3:0]        rk_idx,
    output logic [127:0]      rk_out,
    output logic [1:0]        state_dbg
);

    localparam int Nw = Nb * (Nr + 1);
    localparam int IW = $clog2(Nw);

    word_t         r_w [0:Nw-1];
    ks_state_t     r_state;
    ks_state_t     w_state_next;
    logic [IW-1:0] r_i;      // index of the next word to write
    logic [2:0]    r_sub;    // r_i mod Nk
    logic [3:0]    r_rnd;    // r_i / Nk, selects Rcon
    logic          r_sched_valid;

    logic          w_accept;
    logic          w_last;
    word_t         w_prev;
    word_t         w_back;
    word_t         w_sw_in;
    word_t         w_sw_out;
    word_t         w_temp;
    logic [IW-1:0] w_rb;

    assign key_ready   = (r_state != KS_EXPAND);
    assign sched_valid = r_sched_valid;
    assign state_dbg   = r_state;

    // rst has priority over a simultaneous key_valid.
    assign w_accept = key_valid && key_ready && !rst;
    assign w_last   = (r_i == IW'(Nw - 1));

    // Temp-word datapath. w_prev / w_back only matter while expanding,
    // when r_i is in Nk..Nw-1 and both indices are in range.
    assign w_prev  = r_w[r_i - IW'(1)];
    assign w_back  = r_w[r_i - IW'(Nk)];
    assign w_sw_in = (r_sub == 3'd0) ? {w_prev[8:31], w_prev[0:7]} : w_prev;

    aes_sub_word u_sub_word (
        .i_word (w_sw_in),
        .o_word (w_sw_out)
    );

    always_comb begin
        w_temp = w_prev;
        if (r_sub == 3'd0) begin
            w_temp = w_sw_out ^ {rcon(r_rnd), 24'h000000};
        end else if ((Nk == 8) && (r_sub == 3'd4)) begin
            w_temp = w_sw_out;
        end
    end

    // FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= KS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            KS_IDLE, KS_DONE: begin
                if (w_accept) begin
                    w_state_next = KS_EXPAND;
                end
            end
            KS_EXPAND: begin
                if (w_last) begin
                    w_state_next = KS_DONE;
                end
            end
            default: w_state_next = KS_IDLE;
        endcase
    end

    // Counters and schedule-valid flag. sched_valid rises one edge after
    // the FSM reaches DONE and drops on the edge that accepts a new key.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i           <= '0;
            r_sub         <= '0;
            r_rnd         <= '0;
            r_sched_valid <= 1'b0;
        end else begin
            r_sched_valid <= (r_state == KS_DONE) && !w_accept;
            if (w_accept) begin
                r_i   <= IW'(Nk);
                r_sub <= 3'd0;
                r_rnd <= 4'd1;
            end else if (r_state == KS_EXPAND) begin
                r_i <= r_i + IW'(1);
                if (r_sub == 3'(Nk - 1)) begin
                    r_sub <= 3'd0;
                    r_rnd <= r_rnd + 4'd1;
                end else begin
                    r_sub <= r_sub + 3'd1;
                end
            end
        end
    end

    // Word store, intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < Nk; k++) begin
                r_w[k] <= key_in[k*32 +: 32];
            end
        end else if (!rst && (r_state == KS_EXPAND)) begin
            r_w[r_i] <= w_back ^ w_temp;
        end
    end

    // Registered read port.
    assign w_rb = IW'({rk_idx, 2'b00});

    always_ff @(posedge clk) begin
        if (rst) begin
            rk_out <= '0;
        end else if (rk_idx > 4'(Nr)) begin
            rk_out <= '0;
        end else begin
            rk_out <= {r_w[w_rb], r_w[w_rb + IW'(1)],
                       r_w[w_rb + IW'(2)], r_w[w_rb + IW'(3)]};
        end
    end

endmodule
